// File: rtl/pwm_capture_if.sv
// Link-side bundle for the PWM duty recovery block: gated waveform in, recovered sample and status out.
interface pwm_capture_if #(
    parameter int WIDTH = 8
);
    logic             hsync;
    logic             pwm_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             multi_pulse;
    logic             saturated;
    logic             abort;

    modport master (
        output hsync,
        output pwm_in,
        input  data_out,
        input  data_valid,
        input  multi_pulse,
        input  saturated,
        input  abort
    );

    modport slave (
        input  hsync,
        input  pwm_in,
        output data_out,
        output data_valid,
        output multi_pulse,
        output saturated,
        output abort
    );
endinterface

// File: rtl/pwm_capture.sv
// Recovers an 8-bit duty value per hsync-gated frame by counting high clocks of pwm_in.
// Frames run back-to-back while hsync stays high; hsync falling mid-frame discards the frame.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a low-to-high transition on synchronized hsync
//   MEASURE | counting high clocks and pwm edges across PERIOD clocks
module pwm_capture #(
    parameter int WIDTH       = 8,
    parameter int PERIOD      = 256,
    parameter int SYNC_STAGES = 2
) (
    input logic         clk,
    input logic         rst,
    pwm_capture_if.slave cap
);
    // PERIOD must be at least 2 so frame_cnt has a nonzero width.
    localparam int FCW = $clog2(PERIOD);
    localparam int WW  = $clog2(SYNC_STAGES + 1);

    localparam logic [FCW-1:0] LAST_CNT = FCW'(PERIOD - 1);
    localparam logic [WIDTH:0] HMAX     = {(WIDTH + 1){1'b1}};

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] pwm_sync;
    logic [SYNC_STAGES-1:0] hs_sync;
    logic                   pwm_s;
    logic                   hs_s;
    logic                   hs_q;
    logic                   pwm_q;
    logic [WW-1:0]          warm;
    logic [FCW-1:0]         frame_cnt;
    logic [WIDTH:0]         high_cnt;
    logic [1:0]             edge_cnt;

    logic [WIDTH-1:0]       data_r;
    logic                   valid_r;
    logic                   multi_r;
    logic                   sat_r;
    logic                   abort_r;

    logic [WIDTH:0]         hi_next;
    logic [1:0]             edge_next;
    logic                   frame_end;
    logic                   rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_sync <= '0;
            hs_sync  <= '0;
        end else begin
            pwm_sync[0] <= cap.pwm_in;
            hs_sync[0]  <= cap.hsync;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pwm_sync[i] <= pwm_sync[i-1];
                hs_sync[i]  <= hs_sync[i-1];
            end
        end
    end

    assign pwm_s = pwm_sync[SYNC_STAGES-1];
    assign hs_s  = hs_sync[SYNC_STAGES-1];

    always_comb begin
        hi_next   = (high_cnt == HMAX) ? HMAX : high_cnt + {{WIDTH{1'b0}}, pwm_s};
        edge_next = (edge_cnt == 2'd2) ? 2'd2 : edge_cnt + {1'b0, pwm_s & ~pwm_q};
        frame_end = (frame_cnt == LAST_CNT);
        rise      = hs_s & ~hs_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hs_q      <= 1'b1;
            pwm_q     <= 1'b0;
            warm      <= WW'(SYNC_STAGES);
            frame_cnt <= '0;
            high_cnt  <= '0;
            edge_cnt  <= '0;
            data_r    <= '0;
            valid_r   <= 1'b0;
            multi_r   <= 1'b0;
            sat_r     <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            abort_r <= 1'b0;

            // The sync chain comes out of reset full of zeros; holding hs_q high until it
            // has flushed stops an hsync held high through reset from looking like a rise.
            if (warm != '0) begin
                warm <= warm - WW'(1);
                hs_q <= 1'b1;
            end else begin
                hs_q <= hs_s;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= MEASURE;
                        frame_cnt <= '0;
                        high_cnt  <= '0;
                        edge_cnt  <= '0;
                        pwm_q     <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!hs_s) begin
                        abort_r <= 1'b1;
                        state   <= IDLE;
                    end else if (frame_end) begin
                        valid_r   <= 1'b1;
                        data_r    <= hi_next[WIDTH] ? {WIDTH{1'b1}} : hi_next[WIDTH-1:0];
                        sat_r     <= hi_next[WIDTH];
                        multi_r   <= (edge_next == 2'd2);
                        frame_cnt <= '0;
                        high_cnt  <= '0;
                        edge_cnt  <= '0;
                        pwm_q     <= 1'b0;
                    end else begin
                        frame_cnt <= frame_cnt + FCW'(1);
                        high_cnt  <= hi_next;
                        edge_cnt  <= edge_next;
                        pwm_q     <= pwm_s;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cap.data_out    = data_r;
    assign cap.data_valid  = valid_r;
    assign cap.multi_pulse = multi_r;
    assign cap.saturated   = sat_r;
    assign cap.abort       = abort_r;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: pin-level stimulus is built up front, then a frame-level model
// derives the expected per-cycle outputs which are compared every clock.
module tb_pwm_capture;
    localparam int PERIOD = 256;
    localparam int WIDTH  = 8;
    localparam int SYNC   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_capture_if #(.WIDTH(WIDTH)) cap_if ();

    pwm_capture #(
        .WIDTH      (WIDTH),
        .PERIOD     (PERIOD),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cap(cap_if)
    );

    bit st_rst[$];
    bit st_hs[$];
    bit st_pw[$];

    bit ev_v[];
    bit ev_a[];
    int ev_d[];
    bit ev_m[];
    bit ev_s[];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input bit r, input bit h, input bit p, input int n);
        repeat (n) begin
            st_rst.push_back(r);
            st_hs.push_back(h);
            st_pw.push_back(p);
        end
    endtask

    // One frame of pwm samples with hsync high; keep < PERIOD truncates it so hsync can drop mid-frame.
    task automatic add_frame(input int mode, input int keep);
        int a, la, b, lb;
        bit p;
        a  = $urandom_range(0, 120);
        la = $urandom_range(1, 60);
        b  = $urandom_range(130, 250);
        lb = $urandom_range(1, 40);
        for (int i = 0; i < PERIOD && i < keep; i++) begin
            case (mode)
                0:       p = bit'($urandom % 2);
                1:       p = 1'b1;
                2:       p = 1'b0;
                default: p = (i >= a && i < a + la) || (i >= b && i < b + lb);
            endcase
            push(1'b0, 1'b1, p, 1);
        end
    endtask

    task automatic build_stimulus();
        int nfr, keep;
        push(1'b1, 1'b0, 1'b0, 4);
        push(1'b0, 1'b0, 1'b0, 6);
        // 20 high clocks
        push(1'b0, 1'b1, 1'b0, 1);
        push(1'b0, 1'b1, 1'b1, 20);
        push(1'b0, 1'b1, 1'b0, 236);
        push(1'b0, 1'b0, 1'b0, 5);
        // whole frame high -> clamp
        push(1'b0, 1'b1, 1'b1, 1 + PERIOD);
        push(1'b0, 1'b0, 1'b0, 5);
        // empty frame then 100 high, back-to-back
        push(1'b0, 1'b1, 1'b0, 1 + PERIOD);
        push(1'b0, 1'b1, 1'b1, 100);
        push(1'b0, 1'b1, 1'b0, 156);
        push(1'b0, 1'b0, 1'b0, 4);
        // two pulses
        push(1'b0, 1'b1, 1'b0, 31);
        push(1'b0, 1'b1, 1'b1, 10);
        push(1'b0, 1'b1, 1'b0, 20);
        push(1'b0, 1'b1, 1'b1, 5);
        push(1'b0, 1'b1, 1'b0, 191);
        push(1'b0, 1'b0, 1'b0, 4);
        // hsync drop at frame clock 100, then a fresh frame
        push(1'b0, 1'b1, 1'b0, 1);
        push(1'b0, 1'b1, 1'b1, 100);
        push(1'b0, 1'b0, 1'b0, 4);
        push(1'b0, 1'b1, 1'b1, 1);
        add_frame(0, PERIOD);
        push(1'b0, 1'b0, 1'b0, 4);
        // hsync drop on the last frame clock
        push(1'b0, 1'b1, 1'b0, 1);
        push(1'b0, 1'b1, 1'b1, PERIOD - 1);
        push(1'b0, 1'b0, 1'b0, 4);
        // reset mid-frame with hsync held high, then a real transition
        push(1'b0, 1'b1, 1'b0, 1);
        push(1'b0, 1'b1, 1'b1, 50);
        push(1'b1, 1'b1, 1'b1, 2);
        push(1'b0, 1'b1, 1'b1, 20);
        push(1'b0, 1'b0, 1'b0, 3);
        push(1'b0, 1'b1, 1'b0, 1);
        add_frame(3, PERIOD);
        push(1'b0, 1'b0, 1'b0, 4);
        for (int it = 0; it < 10; it++) begin
            push(1'b0, 1'b0, bit'($urandom % 2), $urandom_range(1, 6));
            push(1'b0, 1'b1, bit'($urandom % 2), 1);
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                keep = PERIOD;
                if (f == nfr - 1 && $urandom_range(0, 4) == 0) keep = $urandom_range(0, PERIOD);
                add_frame($urandom_range(0, 3), keep);
            end
            push(1'b0, 1'b0, 1'b0, $urandom_range(2, 5));
        end
        push(1'b0, 1'b0, 1'b0, 10);
    endtask

    // Pin j reaches the measurement logic SYNC clocks late, so its consequence is visible in
    // cycle j+SYNC. A reset within that window swallows the sample.
    task automatic build_expect();
        int n, sum, edges;
        bit idle, prev, near, pp;
        bit fr[$];
        n    = st_hs.size();
        ev_v = new[n + SYNC + 1];
        ev_a = new[n + SYNC + 1];
        ev_d = new[n + SYNC + 1];
        ev_m = new[n + SYNC + 1];
        ev_s = new[n + SYNC + 1];
        idle = 1'b1;
        prev = 1'b1;
        for (int j = 0; j < n; j++) begin
            near = 1'b0;
            for (int k = 0; k <= SYNC; k++)
                if (j + k < n && st_rst[j + k]) near = 1'b1;
            if (near) begin
                idle = 1'b1;
                prev = 1'b1;
                fr.delete();
                continue;
            end
            if (idle) begin
                if (st_hs[j] && !prev) begin
                    idle = 1'b0;
                    fr.delete();
                end
            end else if (!st_hs[j]) begin
                ev_a[j + SYNC] = 1'b1;
                idle = 1'b1;
            end else begin
                fr.push_back(st_pw[j]);
                if (fr.size() == PERIOD) begin
                    sum   = 0;
                    edges = 0;
                    pp    = 1'b0;
                    foreach (fr[i]) begin
                        sum += int'(fr[i]);
                        if (fr[i] && !pp) edges++;
                        pp = fr[i];
                    end
                    ev_v[j + SYNC] = 1'b1;
                    ev_d[j + SYNC] = (sum > 255) ? 255 : sum;
                    ev_s[j + SYNC] = (sum > 255);
                    ev_m[j + SYNC] = (edges >= 2);
                    fr.delete();
                end
            end
            prev = st_hs[j];
        end
    endtask

    initial begin
        int n, cur_d;
        bit cur_m, cur_s, e_v, e_a;
        build_stimulus();
        build_expect();
        n     = st_hs.size();
        cur_d = 0;
        cur_m = 1'b0;
        cur_s = 1'b0;
        rst           = st_rst[0];
        cap_if.hsync  = st_hs[0];
        cap_if.pwm_in = st_pw[0];
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(negedge clk);
                rst           = st_rst[c];
                cap_if.hsync  = st_hs[c];
                cap_if.pwm_in = st_pw[c];
            end
            @(posedge clk);
            #1;
            if (st_rst[c]) begin
                cur_d = 0;
                cur_m = 1'b0;
                cur_s = 1'b0;
                e_v   = 1'b0;
                e_a   = 1'b0;
            end else begin
                e_v = ev_v[c];
                e_a = ev_a[c];
                if (e_v) begin
                    cur_d = ev_d[c];
                    cur_m = ev_m[c];
                    cur_s = ev_s[c];
                end
            end
            chk("data_valid", c, 32'(cap_if.data_valid), 32'(e_v));
            chk("abort", c, 32'(cap_if.abort), 32'(e_a));
            chk("data_out", c, 32'(cap_if.data_out), 32'(cur_d));
            chk("multi_pulse", c, 32'(cap_if.multi_pulse), 32'(cur_m));
            chk("saturated", c, 32'(cap_if.saturated), 32'(cur_s));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
